imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pkg.sv | 21 ++
 rtl/imm_ext_core.sv | 31 +++
 rtl/imm_ext_pipe.sv | 124 ++++++++++++
 tb/tb_imm_ext_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared mode encodings for the immediate-extension pipe
package imm_ext_pkg;

    typedef enum logic [2:0] {
        MODE_ZEXT5  = 3'b000,
        MODE_ZEXT8  = 3'b001,
        MODE_SEXT5  = 3'b010,
        MODE_SEXT8  = 3'b011,
        MODE_SEXT11 = 3'b100,
        MODE_HI8    = 3'b101,
        MODE_ILL6   = 3'b110,
        MODE_ILL7   = 3'b111
    } imm_mode_e;

    localparam int ERR_CNT_W = 8;

    function automatic logic mode_is_legal(input logic [2:0] m);
        return (m != MODE_ILL6) && (m != MODE_ILL7);
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational immediate extraction and zero/sign extension
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [15:0]   instr,
    input  logic [2:0]    mode,
    output logic [DW-1:0] imm,
    output logic          err
);

    logic [4:0] unused_bits;
    assign unused_bits = instr[15:11];

    // Size casts of $signed operands replicate the source sign bit up to DW-1.
    always_comb begin
        imm = '0;
        err = !mode_is_legal(mode);
        case (imm_mode_e'(mode))
            MODE_ZEXT5:  imm = DW'(instr[4:0]);
            MODE_ZEXT8:  imm = DW'(instr[7:0]);
            MODE_SEXT5:  imm = DW'($signed(instr[4:0]));
            MODE_SEXT8:  imm = DW'($signed(instr[7:0]));
            MODE_SEXT11: imm = DW'($signed(instr[10:0]));
            MODE_HI8:    imm = DW'($signed({instr[7:0], 8'h00}));
            default:     imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - immediate extender feeding a DEPTH-entry output buffer
// Optional illegal-mode counter enabled by IMM_EXT_ERRCNT_EN.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              instr,
    input  logic [2:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_imm,
    output logic                     out_err,
    output logic                     err_sticky,
    input  logic                     clr_err,
    output logic [ERR_CNT_W-1:0]     err_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] core_imm;
    logic          core_err;

    imm_ext_core #(.DW(DW)) u_core (
        .instr (instr),
        .mode  (mode),
        .imm   (core_imm),
        .err   (core_err)
    );

    logic [DW:0]   mem_q [DEPTH];
    logic [DW:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          err_sticky_q, err_sticky_d;
    logic          push, pop;

    // Full blocks input regardless of out_ready: no same-cycle pass-through.
    assign in_ready  = (level_q < FULL_LVL);
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign {out_err, out_imm} = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign err_sticky = err_sticky_q;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        err_sticky_d = err_sticky_q;
        if (push) begin
            mem_d[wr_ptr_q] = {core_err, core_imm};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (clr_err) begin
            err_sticky_d = 1'b0;
        end
        if (push && core_err) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            err_sticky_q <= err_sticky_d;
        end
    end

`ifdef IMM_EXT_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && core_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        if (clr_err) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - randomized and directed self-checking bench for imm_ext_pipe
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] instr;
    logic [2:0]  mode;
    logic        out_ready;
    logic        clr_err;

    logic        in_ready16, out_valid16, out_err16, sticky16;
    logic [15:0] out_imm16;
    logic [7:0]  cnt16;
    logic [2:0]  level16;
    logic        in_ready32, out_valid32, out_err32, sticky32;
    logic [31:0] out_imm32;
    logic [7:0]  cnt32;
    logic [2:0]  level32;

    int checks = 0;
    int errors = 0;

    logic [32:0] mq[$];
    logic        m_sticky;
    int          m_cnt;

    always #5 clk = ~clk;

    imm_ext_pipe #(.DW(16), .DEPTH(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .instr(instr), .mode(mode), .out_valid(out_valid16), .out_ready(out_ready),
        .out_imm(out_imm16), .out_err(out_err16), .err_sticky(sticky16),
        .clr_err(clr_err), .err_cnt(cnt16), .level(level16)
    );

    imm_ext_pipe #(.DW(32), .DEPTH(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .mode(mode), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_err(out_err32), .err_sticky(sticky32),
        .clr_err(clr_err), .err_cnt(cnt32), .level(level32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: field value as an integer, two's-complement folded for signed modes.
    function automatic logic [32:0] ref_ext(input logic [15:0] ins, input logic [2:0] m);
        int v;
        case (m)
            3'd0: v = int'(ins) % 32;
            3'd1: v = int'(ins) % 256;
            3'd2: begin v = int'(ins) % 32;   if (v >= 16)    v -= 32;    end
            3'd3: begin v = int'(ins) % 256;  if (v >= 128)   v -= 256;   end
            3'd4: begin v = int'(ins) % 2048; if (v >= 1024)  v -= 2048;  end
            3'd5: begin v = (int'(ins) % 256) * 256; if (v >= 32768) v -= 65536; end
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, 32'(v)};
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef IMM_EXT_ERRCNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_sticky = 1'b0;
            m_cnt    = 0;
        end else begin
            logic [32:0] e;
            logic acc, deq;
            acc = in_valid && (mq.size() < 4);
            deq = out_ready && (mq.size() != 0);
            e   = ref_ext(instr, mode);
            if (deq) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (clr_err) m_sticky = 1'b0;
            if (acc && e[32]) m_sticky = 1'b1;
            if (acc && e[32] && m_cnt < 255) m_cnt++;
            if (clr_err) m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid16", out_valid16, mq.size() != 0);
            chk("out_valid32", out_valid32, mq.size() != 0);
            chk("level16", level16, mq.size());
            chk("level32", level32, mq.size());
            chk("in_ready16", in_ready16, mq.size() < 4);
            chk("in_ready32", in_ready32, mq.size() < 4);
            if (mq.size() != 0) begin
                chk("out_imm16", out_imm16, mq[0][15:0]);
                chk("out_imm32", out_imm32, mq[0][31:0]);
                chk("out_err16", out_err16, mq[0][32]);
                chk("out_err32", out_err32, mq[0][32]);
            end
            chk("sticky16", sticky16, m_sticky);
            chk("sticky32", sticky32, m_sticky);
            chk("err_cnt16", cnt16, exp_cnt(m_cnt));
            chk("err_cnt32", cnt32, exp_cnt(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; mode = '0;
        out_ready = 1'b0; clr_err = 1'b0;

        chk("pin_sext5",  ref_ext(16'h001F, 3'd2), {1'b0, 32'hFFFFFFFF});
        chk("pin_sext11", ref_ext(16'h0480, 3'd4), {1'b0, 32'hFFFFFC80});
        chk("pin_hi8",    ref_ext(16'h00A5, 3'd5), {1'b0, 32'hFFFFA500});
        chk("pin_zext8",  ref_ext(16'h12FF, 3'd1), {1'b0, 32'h000000FF});
        chk("pin_zext5",  ref_ext(16'hFFF3, 3'd0), {1'b0, 32'h00000013});
        chk("pin_illegal", ref_ext(16'hFFFF, 3'd7), {1'b1, 32'h0});

        @(negedge clk);
        chk("rst_valid", out_valid16, 1'b0);
        chk("rst_level", level32, 3'd0);
        chk("rst_ready", in_ready16, 1'b1);
        chk("rst_imm", out_imm32, 32'h0);
        chk("rst_err", out_err16, 1'b0);
        chk("rst_sticky", sticky32, 1'b0);
        chk("rst_cnt", cnt16, 8'd0);
        step();
        rst_n = 1'b1;

        step();
        in_valid = 1'b1; instr = 16'h001F; mode = 3'b010;
        step();
        chk("d16_sext5_valid", out_valid16, 1'b1);
        chk("d16_sext5_imm", out_imm16, 16'hFFFF);
        chk("d16_sext5_err", out_err16, 1'b0);
        instr = 16'h0480; mode = 3'b100;
        step();
        instr = 16'h00A5; mode = 3'b101;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("d32_sext11", out_imm32, 32'hFFFFFC80);
        step();
        chk("d32_hi8", out_imm32, 32'hFFFFA500);
        step();

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; instr = 16'($urandom); mode = 3'($urandom_range(0, 5));
            step();
        end
        in_valid = 1'b0;
        chk("full_level", level16, 3'd4);
        chk("full_ready", in_ready32, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("full_no_pass", level32, 3'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("drained", out_valid16, 1'b0);

        in_valid = 1'b1; mode = 3'b111; instr = 16'h5A5A;
        step();
        chk("ill_err", out_err32, 1'b1);
        chk("ill_imm", out_imm32, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        chk("ill_sticky", sticky16, 1'b1);
        chk("ill_cnt", cnt32, 8'(exp_cnt(2)));
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_sticky", sticky32, 1'b0);
        chk("clr_cnt", cnt16, 8'd0);
        in_valid = 1'b1; clr_err = 1'b1; mode = 3'b110;
        step();
        in_valid = 1'b0; clr_err = 1'b0;
        chk("set_beats_clr", sticky16, 1'b1);
        chk("cnt_clr_wins", cnt16, 8'd0);
        step();

        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = 16'($urandom); mode = 3'($urandom_range(0, 5));
            step();
        end
        chk("pre_rst_level", level16, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid32, 1'b0);
        chk("mid_rst_level", level16, 3'd0);
        step();
        chk("rst_no_accept", level32, 3'd0);
        rst_n = 1'b1; instr = 16'h0003; mode = 3'b000;
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid16, 1'b1);
        chk("post_rst_imm", out_imm16, 16'h0003);
        out_ready = 1'b1;
        step();

        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr = 16'($urandom); mode = 3'($urandom_range(0, 5));
            step();
            chk("stream_level", level32, 3'd1);
        end
        in_valid = 1'b0;
        step();

        clr_err = 1'b1;
        step();
        clr_err = 1'b0; in_valid = 1'b1; mode = 3'b110;
        for (int i = 0; i < 262; i++) step();
        in_valid = 1'b0;
        step();
        chk("cnt_saturate", cnt32, 8'(exp_cnt(255)));

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_err   = ($urandom_range(0, 15) == 0);
            instr     = 16'($urandom);
            mode      = 3'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
